// File: rtl/intra_pred_uv_seq.sv
// Sequential VP8 chroma intra predictor: builds U then V prediction rows in DC/V/H/TM mode
// and streams them one row per beat over a valid/ready handshake.
module intra_pred_uv_seq #(
   parameter int BIT_WIDTH  = 8,
   parameter int BLOCK_SIZE = 8
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start,
   input  logic [1:0]                       mode,
   input  logic                             top_avail,
   input  logic                             left_avail,
   input  logic [BIT_WIDTH-1:0]             top_left_u,
   input  logic [BIT_WIDTH-1:0]             top_left_v,
   input  logic [BIT_WIDTH*BLOCK_SIZE-1:0]  top_u,
   input  logic [BIT_WIDTH*BLOCK_SIZE-1:0]  top_v,
   input  logic [BIT_WIDTH*BLOCK_SIZE-1:0]  left_u,
   input  logic [BIT_WIDTH*BLOCK_SIZE-1:0]  left_v,
   output logic                             busy,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [BIT_WIDTH*BLOCK_SIZE-1:0]  out_data,
   output logic                             out_chan,
   output logic [$clog2(BLOCK_SIZE)-1:0]    out_row,
   output logic                             done
);

   localparam int BW    = BIT_WIDTH;
   localparam int RW    = $clog2(BLOCK_SIZE);
   localparam int ROW_W = BW * BLOCK_SIZE;
   localparam int ACC_W = BW + RW + 1;
   localparam int TM_W  = BW + 2;
   localparam logic [RW:0] LAST_BEAT = {(RW+1){1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SUM  = 2'd1,
      ST_EMIT = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [1:0]         mode_q;
   logic               top_av_q, left_av_q;
   logic [BW-1:0]      tl_u_q, tl_v_q;
   logic [ROW_W-1:0]   top_u_q, top_v_q, left_u_q, left_v_q;
   logic [BW-1:0]      dc_u_q, dc_v_q, dc_u_d, dc_v_d;
   logic [RW:0]        beat_q, beat_d;
   logic               busy_q, busy_d, valid_q, valid_d, done_q, done_d;
   logic [ROW_W-1:0]   data_q;
   logic               chan_q;
   logic [RW-1:0]      row_q;
   logic               capture_s, load_s;
   logic [ROW_W-1:0]   row_s, top_s, left_s;
   logic [BW-1:0]      tl_s, dc_s, lp_s;

   function automatic logic [BW-1:0] dc_calc(input logic [ROW_W-1:0] top_e,
                                             input logic [ROW_W-1:0] left_e,
                                             input logic ta, input logic la);
      logic [ACC_W-1:0] st, sl, acc;
      st = '0;
      sl = '0;
      for (int i = 0; i < BLOCK_SIZE; i++) begin
         st = st + ACC_W'(top_e[i*BW +: BW]);
         sl = sl + ACC_W'(left_e[i*BW +: BW]);
      end
      case ({ta, la})
         2'b11:   acc = (st + sl + ACC_W'(BLOCK_SIZE)) >> (RW + 1);
         2'b10:   acc = (st + ACC_W'(BLOCK_SIZE / 2)) >> RW;
         2'b01:   acc = (sl + ACC_W'(BLOCK_SIZE / 2)) >> RW;
         default: acc = ACC_W'(1'b1) << (BW - 1);
      endcase
      return acc[BW-1:0];
   endfunction

   function automatic logic [BW-1:0] tm_pix(input logic [BW-1:0] t, input logic [BW-1:0] l,
                                            input logic [BW-1:0] c);
      logic signed [TM_W-1:0] s;
      s = $signed({2'b00, t}) + $signed({2'b00, l}) - $signed({2'b00, c});
      if (s[TM_W-1]) begin
         return '0;
      end else if (s[TM_W-2]) begin
         return '1;
      end else begin
         return s[BW-1:0];
      end
   endfunction

   // DC values from the latched edges
   always_comb begin
      dc_u_d = dc_calc(top_u_q, left_u_q, top_av_q, left_av_q);
      dc_v_d = dc_calc(top_v_q, left_v_q, top_av_q, left_av_q);
   end

   // Control FSM: next state, beat counter and handshake outputs
   always_comb begin
      state_d   = state_q;
      busy_d    = busy_q;
      valid_d   = valid_q;
      done_d    = 1'b0;
      beat_d    = beat_q;
      capture_s = 1'b0;
      load_s    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               capture_s = 1'b1;
               busy_d    = 1'b1;
               state_d   = ST_SUM;
            end else begin
               state_d   = ST_IDLE;
            end
         end
         ST_SUM: begin
            beat_d  = '0;
            load_s  = 1'b1;
            valid_d = 1'b1;
            state_d = ST_EMIT;
         end
         ST_EMIT: begin
            if (valid_q && out_ready) begin
               if (beat_q == LAST_BEAT) begin
                  state_d = ST_IDLE;
                  busy_d  = 1'b0;
                  valid_d = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  beat_d  = beat_q + (RW+1)'(1'b1);
                  load_s  = 1'b1;
               end
            end else begin
               state_d = ST_EMIT;
            end
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            valid_d = 1'b0;
         end
      endcase
   end

   // Row generator for the beat about to be loaded; the SUM cycle uses the fresh DC value
   always_comb begin
      row_s = '0;
      if (beat_d[RW]) begin
         top_s  = top_v_q;
         left_s = left_v_q;
         tl_s   = tl_v_q;
         dc_s   = (state_q == ST_SUM) ? dc_v_d : dc_v_q;
      end else begin
         top_s  = top_u_q;
         left_s = left_u_q;
         tl_s   = tl_u_q;
         dc_s   = (state_q == ST_SUM) ? dc_u_d : dc_u_q;
      end
      lp_s = left_s[beat_d[RW-1:0]*BW +: BW];
      for (int i = 0; i < BLOCK_SIZE; i++) begin
         case (mode_q)
            2'd0:    row_s[i*BW +: BW] = dc_s;
            2'd1:    row_s[i*BW +: BW] = top_s[i*BW +: BW];
            2'd2:    row_s[i*BW +: BW] = lp_s;
            default: row_s[i*BW +: BW] = tm_pix(top_s[i*BW +: BW], lp_s, tl_s);
         endcase
      end
   end

   // State, handshake and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         beat_q  <= '0;
         data_q  <= '0;
         chan_q  <= 1'b0;
         row_q   <= '0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         valid_q <= valid_d;
         done_q  <= done_d;
         beat_q  <= beat_d;
         if (load_s) begin
            data_q <= row_s;
            chan_q <= beat_d[RW];
            row_q  <= beat_d[RW-1:0];
         end
      end
   end

   // Operand capture at start acceptance and DC registration in SUM
   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q    <= 2'd0;
         top_av_q  <= 1'b0;
         left_av_q <= 1'b0;
         tl_u_q    <= '0;
         tl_v_q    <= '0;
         top_u_q   <= '0;
         top_v_q   <= '0;
         left_u_q  <= '0;
         left_v_q  <= '0;
         dc_u_q    <= '0;
         dc_v_q    <= '0;
      end else begin
         if (capture_s) begin
            mode_q    <= mode;
            top_av_q  <= top_avail;
            left_av_q <= left_avail;
            tl_u_q    <= top_left_u;
            tl_v_q    <= top_left_v;
            top_u_q   <= top_u;
            top_v_q   <= top_v;
            left_u_q  <= left_u;
            left_v_q  <= left_v;
         end
         if (state_q == ST_SUM) begin
            dc_u_q <= dc_u_d;
            dc_v_q <= dc_v_d;
         end
      end
   end

   assign busy      = busy_q;
   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign out_chan  = chan_q;
   assign out_row   = row_q;
   assign done      = done_q;

endmodule

// File: tb/tb_intra_pred_uv_seq.sv
// Scoreboard bench for intra_pred_uv_seq: expected rows are queued at start and
// compared as the DUT hands over beats.
module tb_intra_pred_uv_seq;

   localparam int BW    = 8;
   localparam int BS    = 8;
   localparam int RW    = 3;
   localparam int ROW_W = BW * BS;

   typedef int arr_t[BS];
   typedef struct {
      logic [ROW_W-1:0] data;
      logic             chan;
      logic [RW-1:0]    row;
      bit               last;
   } beat_t;

   logic             clk, rst, start, top_avail, left_avail, busy, out_valid, out_ready, out_chan, done;
   logic [1:0]       mode;
   logic [BW-1:0]    top_left_u, top_left_v;
   logic [ROW_W-1:0] top_u, top_v, left_u, left_v, out_data;
   logic [RW-1:0]    out_row;

   intra_pred_uv_seq #(.BIT_WIDTH(BW), .BLOCK_SIZE(BS)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode),
      .top_avail(top_avail), .left_avail(left_avail),
      .top_left_u(top_left_u), .top_left_v(top_left_v),
      .top_u(top_u), .top_v(top_v), .left_u(left_u), .left_v(left_v),
      .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_chan(out_chan), .out_row(out_row), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int    n_cmp = 0;
   int    n_err = 0;
   int    n_acc = 0;
   beat_t sb[$];
   bit    rnd_ready = 1'b0;
   bit    pend_done = 1'b0;
   bit    hold_v = 1'b0;
   logic [71:0] hold_all;

   task automatic check_val(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [ROW_W-1:0] model_row(input int md, input bit ta, input bit la, input int tl,
                                                  input arr_t tp, input arr_t lf, input int r);
      int st, sl, dc, p, t;
      logic [ROW_W-1:0] res;
      st = 0; sl = 0; res = '0;
      for (int i = 0; i < BS; i++) begin
         st += tp[i];
         sl += lf[i];
      end
      if (ta && la)  dc = (st + sl + BS) / (2 * BS);
      else if (ta)   dc = (st + BS / 2) / BS;
      else if (la)   dc = (sl + BS / 2) / BS;
      else           dc = 128;
      for (int i = 0; i < BS; i++) begin
         case (md)
            0: p = dc;
            1: p = tp[i];
            2: p = lf[r];
            default: begin
               t = tp[i] + lf[r] - tl;
               p = (t < 0) ? 0 : ((t > 255) ? 255 : t);
            end
         endcase
         res[i*BW +: BW] = p[BW-1:0];
      end
      return res;
   endfunction

   function automatic arr_t fill(input int v);
      arr_t a;
      foreach (a[i]) a[i] = v;
      return a;
   endfunction

   function automatic arr_t ramp(input int step);
      arr_t a;
      foreach (a[i]) a[i] = i * step;
      return a;
   endfunction

   function automatic arr_t rnd_arr();
      arr_t a;
      foreach (a[i]) a[i] = int'($urandom_range(0, 255));
      return a;
   endfunction

   task automatic scramble();
      mode       = 2'($urandom_range(0, 3));
      top_avail  = 1'($urandom_range(0, 1));
      left_avail = 1'($urandom_range(0, 1));
      top_left_u = 8'($urandom);
      top_left_v = 8'($urandom);
      top_u      = {$urandom, $urandom};
      top_v      = {$urandom, $urandom};
      left_u     = {$urandom, $urandom};
      left_v     = {$urandom, $urandom};
   endtask

   task automatic start_block(input int md, input bit ta, input bit la, input int tlu, input int tlv,
                              input arr_t tu, input arr_t lu, input arr_t tv, input arr_t lv,
                              input bit chk_timing);
      beat_t e;
      mode       = 2'(md);
      top_avail  = ta;
      left_avail = la;
      top_left_u = 8'(tlu);
      top_left_v = 8'(tlv);
      for (int i = 0; i < BS; i++) begin
         top_u[i*BW +: BW]  = 8'(tu[i]);
         left_u[i*BW +: BW] = 8'(lu[i]);
         top_v[i*BW +: BW]  = 8'(tv[i]);
         left_v[i*BW +: BW] = 8'(lv[i]);
      end
      start = 1'b1;
      for (int c = 0; c < 2; c++) begin
         for (int r = 0; r < BS; r++) begin
            e.chan = (c == 1);
            e.row  = 3'(r);
            if (c == 0) e.data = model_row(md, ta, la, tlu, tu, lu, r);
            else        e.data = model_row(md, ta, la, tlv, tv, lv, r);
            e.last = (c == 1) && (r == BS - 1);
            sb.push_back(e);
         end
      end
      @(posedge clk); #1;
      start = 1'b0;
      scramble();
      if (chk_timing) begin
         @(negedge clk);
         check_val("busy_n1", {busy, out_valid}, 2'b10);
         @(negedge clk);
         check_val("valid_n2", {out_valid, out_chan, out_row}, {1'b1, 1'b0, 3'd0});
      end
   endtask

   task automatic drain(input bit b2b);
      int k;
      k = 0;
      while ((sb.size() != 0 || (!b2b && busy)) && k < 400) begin
         @(posedge clk); #1;
         k++;
      end
      check_val("drain_in_time", k < 400, 1'b1);
      if (!b2b) begin
         @(posedge clk); #1;
      end
   endtask

   // Ready driver: all-ones, or a random 1/0 pattern for backpressure
   always @(posedge clk) begin
      #1;
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Monitor: scoreboard pops, stall stability and done timing
   always @(negedge clk) begin
      bit exp_done;
      beat_t e;
      exp_done  = pend_done;
      pend_done = 1'b0;
      if (rst) begin
         hold_v = 1'b0;
      end else begin
         if (done || exp_done) check_val("done_pulse", {done, out_valid, busy}, {exp_done, 1'b0, 1'b0});
         if (hold_v) check_val("stall_hold", {out_valid, out_chan, out_row, out_data}, hold_all);
         hold_v = 1'b0;
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check_val("unexpected_beat", {out_chan, out_row}, 72'hFFFF);
            end else begin
               e = sb.pop_front();
               check_val("row_data", out_data, e.data);
               check_val("row_id", {out_chan, out_row}, {e.chan, e.row});
               pend_done = e.last;
               n_acc++;
            end
         end else if (out_valid) begin
            hold_v   = 1'b1;
            hold_all = {1'b1, out_chan, out_row, out_data};
         end
      end
   end

   initial begin
      int k, base;
      rst = 1'b1;
      start = 1'b0;
      out_ready = 1'b1;
      scramble();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_val("reset_state", {busy, out_valid, done, out_chan, out_row, out_data}, 72'h0);
      @(posedge clk); #1;

      // TM clipping
      start_block(3, 1'b1, 1'b1, 0, 255, fill(250), fill(250), fill(0), fill(0), 1'b1);
      drain(1'b0);
      start_block(3, 1'b0, 1'b0, 200, 200, fill(250), fill(10), fill(250), fill(10), 1'b1);
      drain(1'b0);

      // DC availability combinations
      for (int f = 3; f >= 0; f--) begin
         start_block(0, f[1], f[0], 0, 0, fill(100), fill(50), fill(200), fill(20), 1'b1);
         drain(1'b0);
      end

      // V and H with ramp edges
      start_block(1, 1'b0, 1'b0, 9, 9, ramp(16), ramp(8), rnd_arr(), rnd_arr(), 1'b1);
      drain(1'b0);
      start_block(2, 1'b0, 1'b0, 9, 9, ramp(16), ramp(8), rnd_arr(), rnd_arr(), 1'b1);
      drain(1'b0);

      // Backpressure on random blocks
      rnd_ready = 1'b1;
      for (int b = 0; b < 4; b++) begin
         start_block(b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                     rnd_arr(), rnd_arr(), rnd_arr(), rnd_arr(), 1'b1);
         drain(1'b0);
      end
      rnd_ready = 1'b0;

      // Start while busy is ignored, then a start in the done cycle
      start_block(0, 1'b1, 1'b0, 0, 0, rnd_arr(), rnd_arr(), rnd_arr(), rnd_arr(), 1'b1);
      repeat (3) begin
         @(posedge clk); #1;
      end
      mode  = 2'd3;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      drain(1'b1);
      start_block(1, 1'b0, 1'b0, 0, 0, rnd_arr(), rnd_arr(), rnd_arr(), rnd_arr(), 1'b1);
      drain(1'b0);

      // Reset at beat 5
      base = n_acc;
      start_block(3, 1'b0, 1'b0, 60, 70, rnd_arr(), rnd_arr(), rnd_arr(), rnd_arr(), 1'b1);
      k = 0;
      while (n_acc < base + 5 && k < 100) begin
         @(posedge clk); #1;
         k++;
      end
      check_val("reach_beat5", n_acc - base, 5);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      sb.delete();
      @(negedge clk);
      check_val("reset_abort", {busy, out_valid, done, out_chan, out_row, out_data}, 72'h0);
      repeat (6) @(posedge clk);
      #1;
      start_block(2, 1'b0, 1'b0, 0, 0, rnd_arr(), rnd_arr(), rnd_arr(), rnd_arr(), 1'b1);
      drain(1'b0);

      check_val("sb_left", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/intra_pred_uv_seq.md
# intra_pred_uv_seq

Sequential chroma intra predictor for the VP8 encoder datapath. Generates the 8x8 (parametrised) prediction blocks for both U and V in one of four modes (DC, V, H, TrueMotion). Streams them row by row over a valid/ready interface to the residual/SAD stage. Replaces the single-mode combinational TM-only predictor: it adds mode select, DC edge-availability handling, correct clipping, and output backpressure.

## Interface
- BIT_WIDTH, 8: bits per pixel.
- BLOCK_SIZE, 8: block edge length in pixels. Must be a power of two, ≥ 2.

Ports (clock and reset first):
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- mode  in  2  prediction mode: 0 = DC, 1 = V (vertical), 2 = H (horizontal), 3 = TM.
- top_avail  in  1  top edge valid; used by DC only.
- left_avail  in  1  left edge valid; used by DC only.
- top_left_u, top_left_v  in  BIT_WIDTH  corner pixels.
- top_u, top_v  in  BIT_WIDTH*BLOCK_SIZE  top edge; pixel i at [i*BIT_WIDTH +: BIT_WIDTH].
- left_u, left_v  in  BIT_WIDTH*BLOCK_SIZE  left edge; pixel j (row j) at the same packing.
- busy  out  1  high from start acceptance until the last beat is accepted.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  BIT_WIDTH*BLOCK_SIZE  one prediction row; pixel i at [i*BIT_WIDTH +: BIT_WIDTH].
- out_chan  out  1  0 = U, 1 = V.
- out_row  out  log2(BLOCK_SIZE)  row index within the block.
- done  out  1  one-cycle pulse after the final beat.

## Operation
- FSM states: IDLE, SUM, EMIT.
- IDLE → SUM: on start. Latch mode, avail flags, and all edge/corner inputs into internal registers. Input ports are don't-care afterwards.
- SUM → EMIT: unconditional after 1 cycle. Computes and registers dc_u and dc_v.
- EMIT: steps through 2*BLOCK_SIZE beats: U rows 0..BLOCK_SIZE-1, then V rows 0..BLOCK_SIZE-1.
  - The beat advances on out_valid && out_ready.
  - When the last beat is accepted, go to IDLE.
- DC rule, per channel, with S_t = sum of top pixels and S_l = sum of left pixels. Use an accumulator of BIT_WIDTH + log2(2*BLOCK_SIZE) bits.
  - Both edges available: (S_t + S_l + BLOCK_SIZE) >> log2(2*BLOCK_SIZE).
  - Top only: (S_t + BLOCK_SIZE/2) >> log2(BLOCK_SIZE).
  - Left only: (S_l + BLOCK_SIZE/2) >> log2(BLOCK_SIZE).
  - Neither: 1 << (BIT_WIDTH-1).
- V mode: row j pixel i = top[i].
- H mode: row j pixel i = left[j].
- TM mode: t = top[i] + left[j] - top_left, computed signed in BIT_WIDTH+2 bits. Output is t clipped to [0, 2^BIT_WIDTH - 1].
- For V, H and TM, the avail flags are ignored. The caller supplies substituted edge values for unavailable edges.
- start while busy: ignored, with no effect on the current block.

## Timing
- Reset values: busy=0, out_valid=0, out_data=0, out_chan=0, out_row=0, done=0. The FSM returns to IDLE.
- Reset mid-operation aborts the block immediately. done is not pulsed, and no further beats are issued.
- Start acceptance:
  - start is accepted in cycle N.
  - busy=1 from cycle N+1.
  - out_valid=1 from cycle N+2, with beat 0 (U, row 0).
- Output registers:
  - out_data, out_chan and out_row are registered.
  - They hold stable while out_valid=1 and out_ready=0.
  - out_valid never drops before acceptance.
- Throughput: 1 beat per cycle while out_ready=1. A full block takes 2*BLOCK_SIZE+2 cycles from start to IDLE.
- Completion: after the final beat is accepted in cycle M:
  - Cycle M+1: state is IDLE, busy=0, out_valid=0, done=1.
  - A start in cycle M+1 is accepted, so back-to-back blocks are possible.
- out_ready while out_valid=0: ignored.

## Test plan
- TM clipping, mode=3:
  - top_u all 250, left_u all 250, top_left_u 0 → all U pixels 255.
  - top_v all 0, left_v all 0, top_left_v 255 → all V pixels 0.
  - top 250, left 10, corner 200 → all pixels 60.
- DC availability, mode=0, top all 100, left all 50:
  - Both flags set → 75.
  - Top only → 100.
  - Left only → 50.
  - Neither → 128.
- V/H mode: top_u[i]=i*16, left_u[j]=j*8.
  - V → every U row = 0,16,..,112.
  - H → U row j all j*8.
- Backpressure:
  - out_ready toggles 1,0,0,1 randomly → exactly 16 beats in order U0..U7, V0..V7.
  - Data stable during stalls.
  - done exactly 1 cycle after the last accept.
- Start while busy plus back-to-back: a second start pulsed mid-EMIT is ignored. A start in the done cycle yields out_valid 2 cycles later with the new mode.
- Reset at beat 5: rst for 1 cycle → all outputs 0 next cycle, no done. A following start produces a full correct block.
